// File: rtl/esn7e_st_sink.sv
// Receiving end of the esn7e stream: captures valid-only words into a show-ahead FIFO,
// tracks fixed-length frames with a running sum, and discards frames hit by overflow.
module esn7e_st_sink #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic [ADDR_W:0]   fifo_level,
  output logic              frame_done,
  output logic [DATA_W-1:0] frame_sum,
  output logic              frame_err,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [ADDR_W:0]  FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {
    RUN,
    DISCARD
  } state_t;

  // Each entry carries its start-of-frame flag alongside the data word.
  logic [DATA_W:0]     mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     level;
  logic [IDX_W-1:0]    in_idx;
  logic [DATA_W-1:0]   acc;
  state_t              state;

  logic is_full;
  logic is_last;
  logic push;
  logic drop;
  logic pop;

  // Fullness is judged on the level at the start of the cycle, so a pop in the
  // same cycle never rescues a word that arrives while full.
  always_comb begin
    is_full = (level == FULL_LVL);
    is_last = (in_idx == IDX_LAST);
    push    = data_valid && (state == RUN) && !is_full;
    drop    = data_valid && ((state == DISCARD) || is_full);
    pop     = (level != '0) && out_ready;
  end

  always_comb begin
    out_valid  = (level != '0);
    out_data   = '0;
    out_sof    = 1'b0;
    if (out_valid) begin
      out_data = mem[rd_ptr][DATA_W-1:0];
      out_sof  = mem[rd_ptr][DATA_W];
    end
    fifo_level = level;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {(in_idx == '0), data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      in_idx     <= '0;
      acc        <= '0;
      state      <= RUN;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      // The frame index advances on every strobe, dropped or not, to stay aligned with the source.
      if (data_valid) begin
        in_idx <= is_last ? '0 : in_idx + 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (is_last) begin
          frame_sum  <= acc + data_in;
          frame_done <= 1'b1;
          acc        <= '0;
        end else begin
          acc <= acc + data_in;
        end
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + 1'b1;
        end
      end

      case (state)
        RUN: begin
          if (drop) begin
            acc       <= '0;
            frame_err <= 1'b1;
            state     <= is_last ? RUN : DISCARD;
          end
        end
        DISCARD: begin
          if (data_valid && is_last) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
